// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter slice: ALU_Op / alu_cmd codes and
// the arbiter FSM state type.
package alu_pkg;

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_DEC   = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    localparam logic [2:0] CMD_SHL  = 3'b001;
    localparam logic [2:0] CMD_SHR  = 3'b010;
    localparam logic [2:0] CMD_AND  = 3'b011;
    localparam logic [2:0] CMD_OR   = 3'b100;
    localparam logic [2:0] CMD_XOR  = 3'b101;
    localparam logic [2:0] CMD_CLR  = 3'b110;
    localparam logic [2:0] CMD_PAR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bus of the ALU arbiter. The master side issues
// ALU requests and accepts responses; the slave side is the arbiter.
interface alu_arbiter_if;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][1:0] req_op;
    logic [1:0][2:0] req_cmd;
    logic [1:0][7:0] req_a;
    logic [1:0][7:0] req_b;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [7:0]      rsp_data;
    logic            rsp_zero;
    logic            busy;

    modport master (
        output req_valid, req_op, req_cmd, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_op, req_cmd, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, busy
    );

endinterface

// File: rtl/alu.sv
// Team ALU: purely combinational. Logic/shift group selected by alu_cmd when
// alu_op is 00, otherwise decrement, increment or subtract; all mod 256.
module alu
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] alu_cmd,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] rslt,
    output logic       zero
);

    // Result select; unused command codes produce zero.
    always_comb begin
        rslt = 8'h00;
        case (alu_op)
            OP_LOGIC: begin
                case (alu_cmd)
                    CMD_SHL: rslt = in_a << in_b;
                    CMD_SHR: rslt = in_a >> in_b;
                    CMD_AND: rslt = in_a & in_b;
                    CMD_OR:  rslt = in_a | in_b;
                    CMD_XOR: rslt = in_a ^ in_b;
                    CMD_CLR: rslt = 8'h00;
                    CMD_PAR: rslt = {7'd0, ^in_b};
                    default: rslt = 8'h00;
                endcase
            end
            OP_DEC:  rslt = in_a - 8'd1;
            OP_INC:  rslt = in_a + 8'd1;
            OP_SUB:  rslt = in_a - in_b;
            default: rslt = 8'h00;
        endcase
    end

    assign zero = (rslt == 8'h00);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared ALU. One transaction at a
// time: IDLE accepts the winning request, EXEC registers the ALU result,
// RESP presents it to the owning port until that port takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       id_q, id_d;
    logic [1:0] op_q, op_d;
    logic [2:0] cmd_q, cmd_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_zero_q, rsp_zero_d;

    logic       winner;
    logic [1:0] req_ready_c;
    logic [1:0] rsp_valid_c;
    logic [7:0] alu_rslt;
    logic       alu_zero;

    alu u_alu (
        .alu_op  (op_q),
        .alu_cmd (cmd_q),
        .in_a    (a_q),
        .in_b    (b_q),
        .rslt    (alu_rslt),
        .zero    (alu_zero)
    );

    // Pick the winner: a lone requester wins, a tie goes to prio or port 0.
    always_comb begin
        winner = 1'b0;
        if (bus.req_valid == 2'b11) begin
            winner = RR_EN ? prio_q : 1'b0;
        end else if (bus.req_valid[1]) begin
            winner = 1'b1;
        end
    end

    // Next-state, capture and handshake outputs of the transaction FSM.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        op_d        = op_q;
        cmd_d       = cmd_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        req_ready_c = 2'b00;
        rsp_valid_c = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if ((|bus.req_valid) && !reset) begin
                    req_ready_c[winner] = 1'b1;
                    id_d    = winner;
                    op_d    = bus.req_op[winner];
                    cmd_d   = bus.req_cmd[winner];
                    a_d     = bus.req_a[winner];
                    b_d     = bus.req_b[winner];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_rslt;
                rsp_zero_d = alu_zero;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) begin
                    state_d = ST_IDLE;
                    if (RR_EN) begin
                        prio_d = ~prio_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            op_q       <= 2'b00;
            cmd_q      <= 3'b000;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            id_q       <= id_d;
            op_q       <= op_d;
            cmd_q      <= cmd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
